// File: rtl/mips_run_checker_if.sv
// Control and result bus between mips_run_checker and the harness driving it.
// The master side issues start/halt and probe data; the slave side is the checker.
interface mips_run_checker_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CHECKS = 2,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                             start;
    logic                             halt;
    logic [NUM_CHECKS-1:0]            check_mask;
    logic [NUM_CHECKS*DATA_WIDTH-1:0] probe;
    logic [NUM_CHECKS*DATA_WIDTH-1:0] expected;
    logic                             cpu_rst;
    logic                             cpu_en;
    logic                             busy;
    logic                             done;
    logic                             pass;
    logic                             timeout;
    logic [NUM_CHECKS-1:0]            fail_mask;
    logic [CNT_WIDTH-1:0]             cycle_count;

    modport master (
        output start, halt, check_mask, probe, expected,
        input  cpu_rst, cpu_en, busy, done, pass, timeout, fail_mask, cycle_count
    );

    modport slave (
        input  start, halt, check_mask, probe, expected,
        output cpu_rst, cpu_en, busy, done, pass, timeout, fail_mask, cycle_count
    );
endinterface

// File: rtl/mips_run_checker.sv
// Run-control and result checker for the MIPS core: holds the core in reset, runs it
// until halt or a cycle limit, then compares probed registers against expected values.
module mips_run_checker #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_CHECKS   = 2,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned RUN_CYCLES   = 100,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter bit          REQUIRE_HALT = 1'b0
) (
    input logic               clk,
    input logic               rst,
    mips_run_checker_if.slave bus
);
    localparam int unsigned RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_CNT_W-1:0] RST_LAST  = RST_CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RUN_LIMIT = CNT_WIDTH'(RUN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                state;
    logic [RST_CNT_W-1:0]  rst_cnt;
    logic [NUM_CHECKS-1:0] fail_next;
    logic [CNT_WIDTH-1:0]  count_next;

    always_comb begin
        fail_next = '0;
        for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
            fail_next[i] = bus.check_mask[i] &
                (bus.probe[i*DATA_WIDTH +: DATA_WIDTH] != bus.expected[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Saturating: the RUN exit below fires on reaching the limit, so it never wraps.
    always_comb begin
        count_next = bus.cycle_count;
        if (bus.cycle_count != RUN_LIMIT) begin
            count_next = bus.cycle_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            rst_cnt         <= '0;
            bus.cpu_rst     <= 1'b1;
            bus.cpu_en      <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.pass        <= 1'b0;
            bus.timeout     <= 1'b0;
            bus.fail_mask   <= '0;
            bus.cycle_count <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state           <= S_RESET;
                        rst_cnt         <= '0;
                        bus.cpu_rst     <= 1'b1;
                        bus.cpu_en      <= 1'b1;
                        bus.busy        <= 1'b1;
                        bus.done        <= 1'b0;
                        bus.pass        <= 1'b0;
                        bus.timeout     <= 1'b0;
                        bus.fail_mask   <= '0;
                        bus.cycle_count <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state       <= S_RUN;
                        bus.cpu_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_CNT_W'(1);
                    end
                end
                S_RUN: begin
                    bus.cycle_count <= count_next;
                    // Halt on the final permitted cycle still counts as a halt.
                    if (bus.halt || (count_next == RUN_LIMIT)) begin
                        state       <= S_CHECK;
                        bus.cpu_en  <= 1'b0;
                        bus.timeout <= ~bus.halt;
                    end
                end
                S_CHECK: begin
                    state         <= S_DONE;
                    bus.fail_mask <= fail_next;
                    bus.pass      <= (fail_next == '0) && !(REQUIRE_HALT && bus.timeout);
                    bus.busy      <= 1'b0;
                    bus.done      <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
